line_scanout: RTL and testbench

LINE_SCANOUT -- requirements
Module: line_scanout

---
 rtl/line_scanout.sv | 173 +++++++++++++++++
 tb/tb_line_scanout.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scanout.sv
// Double-buffered line scanout: requests each line one line ahead, fills one of two
// line banks from the renderer stream, and replays the other bank to the VGA pins.
module line_scanout #(
    parameter int CORDW   = 11,
    parameter int H_RES   = 1280,
    parameter int V_RES   = 720,
    parameter int V_TOTAL = 741,
    parameter int PIXW    = 16
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic             line_req,
    output logic [CORDW-1:0] line_num,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [PIXW-1:0]  wr_data,
    input  logic             wr_last,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_de,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             underrun,
    output logic             len_err
);

    localparam int               AW        = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [AW-1:0]    ADDR_LAST = AW'(H_RES - 1);
    localparam logic [CORDW-1:0] SY_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] V_ACT     = CORDW'(V_RES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    logic [1:0]       state;
    logic [AW-1:0]    wr_addr;
    logic [1:0]       bank_ok;
    logic [PIXW-1:0]  line_mem [2][H_RES];

    logic             line_start;
    logic [CORDW-1:0] target;
    logic             start_req;
    logic             beat;
    logic             fill_done;
    logic [1:0]       ok_fwd;

    logic [PIXW-1:0]  rd_pix;
    logic             rd_ok;
    logic             hs_d;
    logic             vs_d;
    logic             de_d;

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        line_start = (sx == '0);
        target     = (sy == SY_LAST) ? '0 : sy + CORDW'(1);
        start_req  = line_start && (target < V_ACT) &&
                     ((state == ST_IDLE) || (state == ST_FILL));
        beat       = (state == ST_FILL) && wr_valid;
        fill_done  = beat && (wr_addr == ADDR_LAST);
        // A bank completing on the same cycle it is first read is already valid.
        ok_fwd     = bank_ok;
        if (fill_done) begin
            ok_fwd[line_num[0]] = 1'b1;
        end
    end

    assign wr_ready = (state == ST_FILL);

    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state    <= ST_IDLE;
            line_req <= 1'b0;
            line_num <= '0;
            wr_addr  <= '0;
            bank_ok  <= 2'b00;
            underrun <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            line_req <= 1'b0;
            if (start_req) begin
                line_req <= 1'b1;
                line_num <= target;
            end

            if (beat) begin
                wr_addr <= wr_addr + AW'(1);
                // wr_last must mark exactly the final beat; the length stays fixed either way.
                if (wr_last != fill_done) begin
                    len_err <= 1'b1;
                end
                if (fill_done) begin
                    bank_ok[line_num[0]] <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    bank_ok[line_num[0]] <= 1'b0;
                    wr_addr              <= '0;
                    state                <= ST_FILL;
                end
                ST_FILL: begin
                    if (line_start) begin
                        if (!fill_done) begin
                            underrun <= 1'b1;
                        end
                        state <= start_req ? ST_REQ : ST_IDLE;
                    end else if (fill_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the line RAM is not reset; bank_ok alone decides whether its contents are shown.
    always_ff @(posedge clk_pix) begin
        if (beat) begin
            line_mem[line_num[0]][wr_addr] <= wr_data;
        end
        if (de) begin
            rd_pix <= line_mem[sy[0]][sx[AW-1:0]];
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            hs_d      <= 1'b1;
            vs_d      <= 1'b1;
            de_d      <= 1'b0;
            rd_ok     <= 1'b0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_de    <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            hs_d      <= hsync;
            vs_d      <= vsync;
            de_d      <= de;
            rd_ok     <= de && ok_fwd[sy[0]];
            vga_hsync <= hs_d;
            vga_vsync <= vs_d;
            vga_de    <= de_d;
            if (de_d && rd_ok) begin
                vga_r <= {rd_pix[15:11], rd_pix[15:13]};
                vga_g <= {rd_pix[10:5],  rd_pix[10:9]};
                vga_b <= {rd_pix[4:0],   rd_pix[4:2]};
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_line_scanout.sv
// Directed bench for line_scanout on an 8x4 active / 12x6 total raster.
module tb_line_scanout;

    localparam int CORDW   = 11;
    localparam int H_RES   = 8;
    localparam int V_RES   = 4;
    localparam int V_TOTAL = 6;
    localparam int PIXW    = 16;
    localparam int H_TOTAL = 12;

    logic             clk_pix = 1'b0;
    logic             rst_pix;
    logic [CORDW-1:0] sx, sy;
    logic             hsync, vsync, de;
    logic             line_req;
    logic [CORDW-1:0] line_num;
    logic             wr_valid, wr_ready, wr_last;
    logic [PIXW-1:0]  wr_data;
    logic             vga_hsync, vga_vsync, vga_de;
    logic [7:0]       vga_r, vga_g, vga_b;
    logic             underrun, len_err;

    always #5 clk_pix = ~clk_pix;

    line_scanout #(
        .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .V_TOTAL(V_TOTAL), .PIXW(PIXW)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix),
        .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
        .line_req(line_req), .line_num(line_num),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .underrun(underrun), .len_err(len_err)
    );

    int errors = 0;
    int checks = 0;

    // Renderer plan for the next request, and the fill currently being fed.
    int          plan_beats = 0, plan_last = 8, plan_start = 2;
    logic [15:0] plan_base = '0;
    int          beats_left = 0, beat_idx = 1, cur_last = 8, cur_start = 2;
    logic [15:0] next_data = '0;
    int          req_hi = 0;

    logic [23:0]      cap [V_RES][H_RES];
    int               de_cnt [V_RES];
    logic [CORDW-1:0] p_sx = '1, p_sy = '1;
    logic             p_hs = 1'b1, p_vs = 1'b1, p_de = 1'b0;
    int               skip = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    task automatic set_syncs();
        de    = (sx < CORDW'(H_RES)) && (sy < CORDW'(V_RES));
        hsync = !((sx == CORDW'(9)) || (sx == CORDW'(10)));
        vsync = !(sy == CORDW'(4));
    endtask

    task automatic plan(input int beats, input int last, input int start, input logic [15:0] base);
        plan_beats = beats;
        plan_last  = last;
        plan_start = start;
        plan_base  = base;
    endtask

    task automatic cyc();
        logic acc;
        int   ps, py;
        wr_valid = (beats_left > 0) && ((beat_idx > 1) || (int'(sx) >= cur_start));
        wr_data  = next_data;
        wr_last  = wr_valid && (beat_idx == cur_last);
        acc      = wr_valid && wr_ready;
        @(posedge clk_pix);
        #1;
        if (acc) begin
            beats_left--;
            beat_idx++;
            next_data++;
        end
        if (line_req) begin
            req_hi++;
            beats_left = plan_beats;
            beat_idx   = 1;
            next_data  = plan_base;
            cur_last   = plan_last;
            cur_start  = plan_start;
        end
        if (skip > 0) begin
            skip--;
        end else begin
            check("vga_de_align", 32'(vga_de), 32'(p_de));
            check("vga_hsync_align", 32'(vga_hsync), 32'(p_hs));
            check("vga_vsync_align", 32'(vga_vsync), 32'(p_vs));
        end
        ps = int'(p_sx);
        py = int'(p_sy);
        if (py < V_RES && ps == 0) begin
            de_cnt[py] = 0;
            for (int c = 0; c < H_RES; c++) cap[py][c] = 'x;
        end
        if (vga_de && py < V_RES && ps < H_RES) begin
            de_cnt[py]++;
            cap[py][ps] = {vga_r, vga_g, vga_b};
        end
        p_sx = sx;
        p_sy = sy;
        p_hs = hsync;
        p_vs = vsync;
        p_de = de;
        if (sx == CORDW'(H_TOTAL - 1)) begin
            sx = '0;
            sy = (sy == CORDW'(V_TOTAL - 1)) ? '0 : sy + CORDW'(1);
        end else begin
            sx = sx + CORDW'(1);
        end
        set_syncs();
    endtask

    task automatic run_line();
        repeat (H_TOTAL) cyc();
    endtask

    task automatic check_row(input int row, input logic [15:0] base, input bit black);
        check($sformatf("row%0d_de_count", row), 32'(de_cnt[row]), 32'(H_RES));
        for (int i = 0; i < H_RES; i++) begin
            check($sformatf("row%0d_px%0d", row, i), 32'(cap[row][i]),
                  black ? 32'd0 : 32'(exp_rgb(base + 16'(i))));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_line_req"}, 32'(line_req), 32'd0);
        check({tag, "_line_num"}, 32'(line_num), 32'd0);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
        check({tag, "_len_err"}, 32'(len_err), 32'd0);
        check({tag, "_vga_hsync"}, 32'(vga_hsync), 32'd1);
        check({tag, "_vga_vsync"}, 32'(vga_vsync), 32'd1);
        check({tag, "_vga_de"}, 32'(vga_de), 32'd0);
        check({tag, "_vga_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    endtask

    initial begin
        rst_pix  = 1'b1;
        sx       = '0;
        sy       = '0;
        hsync    = 1'b1;
        vsync    = 1'b1;
        de       = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1;
        check_reset("por");
        rst_pix = 1'b0;
        set_syncs();

        // Frame 0, line 0: request line 1, normal fill; line 0 itself has no data yet.
        plan(8, 8, 2, 16'h0001);
        run_line();
        check("f0l0_line_num", 32'(line_num), 32'd1);
        check("f0l0_req_pulses", 32'(req_hi), 32'd1);
        check("f0l0_wr_ready_idle", 32'(wr_ready), 32'd0);
        check_row(0, 16'h0000, 1'b1);

        // Line 1: request line 2; its fill starts late so the 8th beat lands on the next line start.
        plan(8, 8, 5, 16'hF800);
        run_line();
        check("f0l1_line_num", 32'(line_num), 32'd2);
        check("f0l1_req_pulses", 32'(req_hi), 32'd2);
        check("f0l1_still_filling", 32'(wr_ready), 32'd1);
        check("f0l1_px0_0001", 32'(cap[1][0]), 32'h000008);
        check_row(1, 16'h0001, 1'b0);

        // Line 2: completion coincides with line start, then request line 3.
        plan(8, 8, 2, 16'h0010);
        run_line();
        check("f0l2_line_num", 32'(line_num), 32'd3);
        check("f0l2_req_pulses", 32'(req_hi), 32'd3);
        check("f0l2_no_underrun", 32'(underrun), 32'd0);
        check("f0l2_px0_f800", 32'(cap[2][0]), 32'hFF0000);
        check("f0l2_px7_f807", 32'(cap[2][7]), 32'hFF0039);
        check_row(2, 16'hF800, 1'b0);

        // Lines 3 and 4 target lines 4 and 5: no request.
        run_line();
        check("f0l3_no_req", 32'(req_hi), 32'd3);
        check_row(3, 16'h0010, 1'b0);
        run_line();
        check("f0l4_no_req", 32'(req_hi), 32'd3);
        check("f0l4_len_err_clear", 32'(len_err), 32'd0);

        // Line 5: request line 0 with wr_last misplaced on beat 3.
        plan(8, 3, 2, 16'h1234);
        run_line();
        check("f0l5_line_num", 32'(line_num), 32'd0);
        check("f0l5_req_pulses", 32'(req_hi), 32'd4);
        check("f0l5_len_err", 32'(len_err), 32'd1);
        check("f0l5_all_beats_taken", 32'(beats_left), 32'd0);
        check("f0l5_wr_ready_idle", 32'(wr_ready), 32'd0);

        // Frame 1, line 0: shows line 0 data; line 1 fill gets only 5 beats.
        plan(5, 8, 2, 16'h0100);
        run_line();
        check("f1l0_line_num", 32'(line_num), 32'd1);
        check("f1l0_req_pulses", 32'(req_hi), 32'd5);
        check("f1l0_len_err_sticky", 32'(len_err), 32'd1);
        check_row(0, 16'h1234, 1'b0);

        // Line 1: underrun; line 1 is black with de high; line 2 fill is normal.
        plan(8, 8, 2, 16'h07E0);
        run_line();
        check("f1l1_underrun", 32'(underrun), 32'd1);
        check("f1l1_line_num", 32'(line_num), 32'd2);
        check("f1l1_req_pulses", 32'(req_hi), 32'd6);
        check_row(1, 16'h0000, 1'b1);

        // Line 2: reset in the middle of the line 3 fill.
        plan(8, 8, 2, 16'h4321);
        repeat (5) cyc();
        check("f1l2_req_pulses", 32'(req_hi), 32'd7);
        check("f1l2_mid_fill", 32'(wr_ready), 32'd1);
        check("f1l2_underrun_sticky", 32'(underrun), 32'd1);
        beats_left = 0;
        rst_pix    = 1'b1;
        skip       = 2;
        cyc();
        rst_pix = 1'b0;
        check_reset("mid");
        repeat (H_TOTAL - 6) cyc();
        check("f1l2_px0_07e0", 32'(cap[2][0]), 32'h00FF00);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f1l2_pre_reset_px%0d", i), 32'(cap[2][i]),
                  32'(exp_rgb(16'h07E0 + 16'(i))));
        end
        check("f1l2_post_reset_px6", 32'(cap[2][6]), 32'd0);
        check("f1l2_post_reset_px7", 32'(cap[2][7]), 32'd0);

        // Line 3: abandoned fill, bank_ok cleared by reset, so black with de high.
        run_line();
        check("f1l3_no_req", 32'(req_hi), 32'd7);
        check_row(3, 16'h0000, 1'b1);
        run_line();

        // Line 5: fresh request for line 0, displayed in frame 2.
        plan(8, 8, 2, 16'hABCD);
        run_line();
        check("f1l5_req_pulses", 32'(req_hi), 32'd8);
        check("f1l5_line_num", 32'(line_num), 32'd0);
        run_line();
        check("f2l0_line_num", 32'(line_num), 32'd1);
        check("f2l0_len_err_after_reset", 32'(len_err), 32'd0);
        check("f2l0_underrun_after_reset", 32'(underrun), 32'd0);
        check_row(0, 16'hABCD, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
